// File: rtl/clk_rst_pkg.sv
// Shared clock/reset configuration types: field indices, encodings and sequencer states.
// Optional lock feature of the sequencer is enabled with CLK_CFG_LOCK_EN.
package clk_rst_pkg;

  localparam int CFG_MUX0    = 6;
  localparam int CFG_MUX1    = 5;
  localparam int CFG_MUX2    = 4;
  localparam int CFG_ROSC_HI = 3;
  localparam int CFG_ROSC_LO = 2;
  localparam int CFG_DIV_HI  = 1;
  localparam int CFG_DIV_LO  = 0;

  typedef logic [6:0] clk_cfg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PARK,
    ST_SETTLE_A,
    ST_APPLY,
    ST_SETTLE_B,
    ST_RELEASE,
    ST_DONE
  } state_t;

  localparam logic [1:0] ROSC_128M = 2'b00;
  localparam logic [1:0] ROSC_64M  = 2'b01;
  localparam logic [1:0] ROSC_32M  = 2'b10;
  localparam logic [1:0] ROSC_16M  = 2'b11;

  localparam logic [1:0] DIV_1 = 2'b00;
  localparam logic [1:0] DIV_2 = 2'b01;
  localparam logic [1:0] DIV_4 = 2'b10;
  localparam logic [1:0] DIV_8 = 2'b11;

  localparam clk_cfg_t CLK_CFG_RST = {1'b0, 1'b0, 1'b0, ROSC_16M, DIV_1};

  // Everything upstream of CLKMUX0 (mux1, mux2, rosc, div).
  function automatic logic [5:0] upstream_sel(input clk_cfg_t c);
    return c[CFG_MUX1:CFG_DIV_LO];
  endfunction

endpackage

// File: rtl/clk_cfg_seq_if.sv
// Valid/ready request channel carrying a new clock configuration.
interface clk_cfg_seq_if;
  logic                  cfg_valid;
  logic                  cfg_ready;
  clk_rst_pkg::clk_cfg_t cfg_data;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/clk_cfg_seq_settle_timer.sv
// Loadable down-counter that stops at zero; reused for both settle phases.
module settle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/clk_cfg_seq.sv
// Glitch-safe clock configuration sequencer: park CLKMUX0, change upstream selects, release.
// Define CLK_CFG_LOCK_EN to add the sticky cfg_lock/locked request lock.
module clk_cfg_seq
  import clk_rst_pkg::*;
#(
  parameter int       SETTLE_CYCLES = 16,
  parameter clk_cfg_t RST_CFG       = 7'b0_0_0_11_00
) (
  input  logic           clk,
  input  logic           rst_n,
  clk_cfg_seq_if.slave   cfg,
`ifdef CLK_CFG_LOCK_EN
  input  logic           cfg_lock,
  output logic           locked,
`endif
  output logic           busy,
  output logic           done,
  output logic           sel_mux0,
  output logic           sel_mux1,
  output logic           sel_mux2,
  output logic [1:0]     sel_rosc,
  output logic [1:0]     clk_div,
  output clk_cfg_t       cur_cfg
);

  localparam logic [7:0] LOAD_VAL = 8'(SETTLE_CYCLES - 1);

  state_t   r_state, w_state_next;
  clk_cfg_t r_sel, w_sel_next;
  clk_cfg_t r_cur, w_cur_next;
  clk_cfg_t r_req, w_req_next;
  logic     r_done;
  logic     w_xfer, w_load, w_dec, w_zero, w_lock_block;

  settle_timer #(.WIDTH(8)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

`ifdef CLK_CFG_LOCK_EN
  logic r_locked, r_lock_pend;

  // A lock requested together with an accepted request waits for that request's DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked    <= 1'b0;
      r_lock_pend <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && cfg_lock && !r_locked) begin
        if (w_xfer) r_lock_pend <= 1'b1;
        else        r_locked    <= 1'b1;
      end
      if ((r_state == ST_DONE) && r_lock_pend) begin
        r_locked    <= 1'b1;
        r_lock_pend <= 1'b0;
      end
    end
  end

  assign w_lock_block = r_locked;
  assign locked       = r_locked;
`else
  assign w_lock_block = 1'b0;
`endif

  assign cfg.cfg_ready = (r_state == ST_IDLE) && !w_lock_block;
  assign w_xfer        = cfg.cfg_valid && cfg.cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= RST_CFG;
      r_cur   <= RST_CFG;
      r_req   <= RST_CFG;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_cur   <= w_cur_next;
      r_req   <= w_req_next;
      r_done  <= (r_state == ST_DONE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_cur_next   = r_cur;
    w_req_next   = r_req;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_req_next = cfg.cfg_data;
          if (cfg.cfg_data == r_cur) begin
            w_state_next = ST_DONE;
          end else if (!r_sel[CFG_MUX0]) begin
            // CLKMUX0 already on ROSC: the park step has nothing to do.
            w_load       = 1'b1;
            w_state_next = ST_SETTLE_A;
          end else begin
            w_state_next = ST_PARK;
          end
        end
      end
      ST_PARK: begin
        w_sel_next[CFG_MUX0] = 1'b0;
        w_load               = 1'b1;
        w_state_next         = ST_SETTLE_A;
      end
      ST_SETTLE_A: begin
        if (w_zero) w_state_next = ST_APPLY;
        else        w_dec        = 1'b1;
      end
      ST_APPLY: begin
        w_sel_next   = {r_sel[CFG_MUX0], upstream_sel(r_req)};
        w_load       = 1'b1;
        w_state_next = ST_SETTLE_B;
      end
      ST_SETTLE_B: begin
        if (w_zero) w_state_next = ST_RELEASE;
        else        w_dec        = 1'b1;
      end
      ST_RELEASE: begin
        w_sel_next[CFG_MUX0] = r_req[CFG_MUX0];
        w_cur_next           = r_req;
        w_state_next         = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign sel_mux0 = r_sel[CFG_MUX0];
  assign sel_mux1 = r_sel[CFG_MUX1];
  assign sel_mux2 = r_sel[CFG_MUX2];
  assign sel_rosc = r_sel[CFG_ROSC_HI:CFG_ROSC_LO];
  assign clk_div  = r_sel[CFG_DIV_HI:CFG_DIV_LO];
  assign cur_cfg  = r_cur;

endmodule

// File: tb/tb_clk_cfg_seq.sv
// Randomized bench for clk_cfg_seq against a timeline model of the sequencing rules.
module tb_clk_cfg_seq;
  import clk_rst_pkg::*;

  localparam int       S   = 4;
  localparam clk_cfg_t RST = 7'b0_0_0_11_00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_cfg_seq_if cfg_if ();

  logic       busy, done, sel_mux0, sel_mux1, sel_mux2;
  logic [1:0] sel_rosc, clk_div;
  clk_cfg_t   cur_cfg;
`ifdef CLK_CFG_LOCK_EN
  logic cfg_lock = 1'b0;
  logic locked;
`endif

  clk_cfg_seq #(.SETTLE_CYCLES(S), .RST_CFG(RST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg      (cfg_if),
`ifdef CLK_CFG_LOCK_EN
    .cfg_lock (cfg_lock),
    .locked   (locked),
`endif
    .busy     (busy),
    .done     (done),
    .sel_mux0 (sel_mux0),
    .sel_mux1 (sel_mux1),
    .sel_mux2 (sel_mux2),
    .sel_rosc (sel_rosc),
    .clk_div  (clk_div),
    .cur_cfg  (cur_cfg)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_tx  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: one request in flight, described by accept time offset k and end point E.
  bit       m_act = 0, m_red = 0, m_locked = 0;
  int       m_k = 0, m_e = 0, m_p = 0;
  clk_cfg_t m_cur = RST, m_req = RST;
  bit       exp_busy = 0, exp_ready = 1;
  bit       have_prev = 0;
  logic [6:0] prev_sel;

  function automatic clk_cfg_t dut_sel();
    return {sel_mux0, sel_mux1, sel_mux2, sel_rosc, clk_div};
  endfunction

  task automatic tick(output bit acc);
    clk_cfg_t d;
    bit       lk;
    clk_cfg_t sel_e, cur_e;
    bit       busy_e, done_e;
    d  = cfg_if.cfg_data;
    acc = cfg_if.cfg_valid && exp_ready && rst_n;
`ifdef CLK_CFG_LOCK_EN
    lk = cfg_lock && !exp_busy && rst_n;
`else
    lk = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_act = 0; m_cur = RST; m_locked = 0; have_prev = 0;
    end
    if (lk && !acc) m_locked = 1;
    if (acc) begin
      m_act = 1; m_k = 0; m_req = d;
      m_red = (d == m_cur);
      m_p   = m_cur[CFG_MUX0] ? 1 : 0;
      m_e   = m_red ? 1 : m_p + 2 * S + 3;
      n_tx++;
      $display("tx %0d: %b -> %b %s", n_tx, m_cur, d, m_red ? "(redundant)" : "");
    end else if (m_act) begin
      m_k++;
    end
    sel_e = m_cur; cur_e = m_cur; busy_e = 0; done_e = 0;
    if (m_act) begin
      if (!m_red) begin
        if (m_k >= 1) sel_e[CFG_MUX0] = 1'b0;
        if (m_k >= m_p + S + 1) sel_e[5:0] = m_req[5:0];
        if (m_k >= m_e - 1) begin
          sel_e[CFG_MUX0] = m_req[CFG_MUX0];
          cur_e = m_req;
        end
      end
      busy_e = (m_k < m_e);
      done_e = (m_k == m_e);
    end
    exp_busy  = busy_e;
    exp_ready = !busy_e && !m_locked;
    chk("sel", dut_sel(), sel_e);
    chk("cur_cfg", cur_cfg, cur_e);
    chk("busy", busy, busy_e);
    chk("done", done, done_e);
    chk("ready", cfg_if.cfg_ready, exp_ready);
`ifdef CLK_CFG_LOCK_EN
    chk("locked", locked, m_locked);
`endif
    // CLKMUX0 must be low on both sides of any upstream select change.
    if (have_prev && (dut_sel() & 7'h3f) != (prev_sel & 7'h3f))
      chk("mux0_low", {prev_sel[CFG_MUX0], sel_mux0}, 0);
    prev_sel  = dut_sel();
    have_prev = rst_n;
    if (m_act && m_k == m_e) begin
      m_act = 0;
      m_cur = m_req;
    end
  endtask

  task automatic send(input clk_cfg_t d);
    bit acc;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = d;
    for (int i = 0; i < 200; i++) begin
      tick(acc);
      if (acc) break;
    end
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = $urandom_range(0, 127);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic wait_idle();
    bit acc;
    for (int i = 0; i < 100 && m_act; i++) tick(acc);
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
    idle(2);
    @(negedge clk) rst_n = 1'b1;
    idle(5);

    send(7'b1_1_1_00_10); wait_idle();
    send(7'b1_1_1_00_10); wait_idle();
    send(7'b1_1_0_00_00); wait_idle();
    send(7'b1_0_0_01_01); wait_idle();

    for (int t = 0; t < 40; t++) begin
      clk_cfg_t d;
      d = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) d = m_cur;
      send(d);
      if ($urandom_range(0, 1) == 1) wait_idle();
      idle($urandom_range(0, 2));
    end
    wait_idle();

    // Reset in the middle of the second settle phase.
    if (m_cur[CFG_MUX0] == 1'b0) begin
      send(m_cur | 7'b1000000); wait_idle();
    end
    send(m_cur ^ 7'b0100000);
    for (int i = 0; i < 100 && m_k != m_p + S + 2; i++) idle(1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_sel", dut_sel(), RST);
    chk("async_rst_cur", cur_cfg, RST);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    idle(2);
    @(negedge clk) rst_n = 1'b1;
    idle(6);

`ifdef CLK_CFG_LOCK_EN
    cfg_lock = 1'b1;
    idle(1);
    cfg_lock = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 7'b1_0_1_10_11;
    idle(2 * S + 8);
    cfg_if.cfg_valid = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
